// File: rtl/decoder_pipe.sv
// decoder_pipe: registered binary-index-to-vector decoder with valid/ready
// handshakes on both sides. A 2-entry store (output register + skid register)
// keeps full throughput under backpressure. MODE 0 is one-hot, MODE 1 is
// thermometer. Indices >= OUT_W with in_en=1 are flagged on out_err.
// Optional macro DECODER_PIPE_CNT_EN adds dec_cnt, a free-running count of
// error-free output transfers.

module decoder_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_idx,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_vec,
  output logic             out_err
`ifdef DECODER_PIPE_CNT_EN
  ,
  output logic [31:0]      dec_cnt
`endif
);

  // Catch illegal parameterisations at elaboration time.
  if (IN_W < 1 || IN_W > 6) begin : g_bad_in_w
    $error("decoder_pipe: IN_W must be 1..6");
  end
  if (OUT_W < 1 || OUT_W > (1 << IN_W)) begin : g_bad_out_w
    $error("decoder_pipe: OUT_W must be 1..2**IN_W");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("decoder_pipe: MODE must be 0 or 1");
  end

  // OUT_W expressed one bit wider than the index so 2**IN_W is representable.
  localparam logic [IN_W:0] OUT_W_L = (IN_W+1)'(OUT_W);

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_vec_q,   out_vec_d;
  logic             out_err_q,   out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_vec_q,  skid_vec_d;
  logic             skid_err_q,  skid_err_d;
  logic             in_ready_q,  in_ready_d;

  logic [OUT_W-1:0] dec_vec;
  logic             dec_err;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // Decode the incoming index into a one-hot or thermometer vector.
  always_comb begin
    dec_vec = '0;
    dec_err = 1'b0;
    if (in_en) begin
      if ({1'b0, in_idx} >= OUT_W_L) begin
        dec_err = 1'b1;
      end else begin
        for (int i = 0; i < OUT_W; i++) begin
          if (MODE == 1) begin
            dec_vec[i] = (IN_W'(i) <= in_idx);
          end else begin
            dec_vec[i] = (IN_W'(i) == in_idx);
          end
        end
      end
    end
  end

  // Next state of the output/skid pair; flush overrides every load.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_vec_d    = out_vec_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_vec_d   = skid_vec_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_vec_d    = skid_vec_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_vec_d   = dec_vec;
        out_err_d   = dec_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_vec_d   = dec_vec;
      skid_err_d   = dec_err;
    end
    in_ready_d = !skid_valid_d;
  end

  // Register the pipeline state; reset empties both entries and drops in_ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_vec_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_vec_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_vec_q    <= out_vec_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_vec_q   <= skid_vec_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_err   = out_err_q;

`ifdef DECODER_PIPE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Count error-free output transfers, including one that lands on a flush.
  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer && !out_err_q) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dec_cnt = cnt_q;
`else
  logic unused_out_xfer;
  assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: drives three decoder_pipe configurations with a shared
// handshake: (IN_W 4, OUT_W 16, one-hot), (IN_W 4, OUT_W 12, one-hot) and
// (IN_W 3, OUT_W 8, thermometer). Directed scenarios plus a randomized run
// checked against a depth-2 FIFO reference model. Honours DECODER_PIPE_CNT_EN.

module tb_decoder_pipe;

  logic       clk;
  logic       resetn;
  logic       flush;
  logic       in_valid;
  logic [3:0] in_idx;
  logic       in_en;
  logic       out_ready;

  logic        u0_in_ready, u0_out_valid, u0_out_err;
  logic [15:0] u0_out_vec;
  logic        u1_in_ready, u1_out_valid, u1_out_err;
  logic [11:0] u1_out_vec;
  logic        u2_in_ready, u2_out_valid, u2_out_err;
  logic [7:0]  u2_out_vec;
`ifdef DECODER_PIPE_CNT_EN
  logic [31:0] u0_cnt, u1_cnt, u2_cnt;
`endif

  int tests_run;
  int tests_failed;

  decoder_pipe #(.IN_W(4), .OUT_W(16), .MODE(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(u0_in_ready), .in_idx(in_idx), .in_en(in_en),
    .out_valid(u0_out_valid), .out_ready(out_ready), .out_vec(u0_out_vec),
    .out_err(u0_out_err)
`ifdef DECODER_PIPE_CNT_EN
    , .dec_cnt(u0_cnt)
`endif
  );

  decoder_pipe #(.IN_W(4), .OUT_W(12), .MODE(0)) u_dut1 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(u1_in_ready), .in_idx(in_idx), .in_en(in_en),
    .out_valid(u1_out_valid), .out_ready(out_ready), .out_vec(u1_out_vec),
    .out_err(u1_out_err)
`ifdef DECODER_PIPE_CNT_EN
    , .dec_cnt(u1_cnt)
`endif
  );

  decoder_pipe #(.IN_W(3), .OUT_W(8), .MODE(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
    .in_ready(u2_in_ready), .in_idx(in_idx[2:0]), .in_en(in_en),
    .out_valid(u2_out_valid), .out_ready(out_ready), .out_vec(u2_out_vec),
    .out_err(u2_out_err)
`ifdef DECODER_PIPE_CNT_EN
    , .dec_cnt(u2_cnt)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int idx;
    bit en;
  } ent_t;

  ent_t        mdl_q[$];
  bit          mdl_rdy;
  bit          mdl_in_x;
  bit          mdl_out_x;
  logic [31:0] mdl_cnt[3];

  function automatic int outw_for(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 12 : 8);
  endfunction

  function automatic int mode_for(input int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int idx_for(input int k, input int idx);
    return (k == 2) ? (idx % 8) : idx;
  endfunction

  function automatic bit ref_err(input int idx, input bit en, input int outw);
    return en && (idx >= outw);
  endfunction

  function automatic logic [63:0] ref_vec(input int idx, input bit en,
                                          input int outw, input int mode);
    logic [63:0] one;
    one = 64'd1;
    if (!en || idx >= outw) return 64'd0;
    if (mode == 0) return one << idx;
    return ((one << idx) << 1) - 64'd1;
  endfunction

  // The model is a FIFO of at most two accepted entries.
  always @(posedge clk) begin
    if (!resetn) begin
      mdl_q.delete();
      mdl_rdy = 1'b0;
      for (int k = 0; k < 3; k++) mdl_cnt[k] = 32'd0;
    end else begin
      mdl_in_x  = in_valid && mdl_rdy;
      mdl_out_x = (mdl_q.size() != 0) && out_ready;
      if (mdl_out_x) begin
        for (int k = 0; k < 3; k++) begin
          if (!ref_err(idx_for(k, mdl_q[0].idx), mdl_q[0].en, outw_for(k)))
            mdl_cnt[k] = mdl_cnt[k] + 32'd1;
        end
        void'(mdl_q.pop_front());
      end
      if (mdl_in_x && !flush) mdl_q.push_back('{idx: int'(in_idx), en: in_en});
      if (flush) mdl_q.delete();
      mdl_rdy = (mdl_q.size() < 2);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit v, input logic [3:0] idx, input bit en);
    in_valid = v;
    in_idx   = idx;
    in_en    = en;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
    repeat (3) tick();
    tests_run++;
    if ({u0_out_valid, u1_out_valid, u2_out_valid} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid: got %b expected 000",
               {u0_out_valid, u1_out_valid, u2_out_valid});
    end
    tests_run++;
    if ({u0_out_vec, u1_out_vec, u2_out_vec, u0_out_err, u1_out_err, u2_out_err} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_vec_err: got %h/%h/%h err %b%b%b expected all zero",
               u0_out_vec, u1_out_vec, u2_out_vec, u0_out_err, u1_out_err, u2_out_err);
    end
    tests_run++;
    if ({u0_in_ready, u1_in_ready, u2_in_ready} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 000",
               {u0_in_ready, u1_in_ready, u2_in_ready});
    end
`ifdef DECODER_PIPE_CNT_EN
    tests_run++;
    if (u0_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", u0_cnt);
    end
`endif
    resetn = 1'b1;
    tick();
    tests_run++;
    if (u0_in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release_in_ready: got %b expected 1", u0_in_ready);
    end
  endtask

  task automatic test_stream();
    logic [3:0]  idxs [3];
    logic [15:0] exps [3];
    idxs = '{4'd0, 4'd5, 4'd15};
    exps = '{16'h0001, 16'h0020, 16'h8000};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, idxs[i], 1'b1);
      tick();
      tests_run++;
      if (u0_out_valid !== 1'b1 || u0_out_vec !== exps[i] || u0_in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stream_%0d: got valid %b vec %h rdy %b expected 1 %h 1",
                 i, u0_out_valid, u0_out_vec, u0_in_ready, exps[i]);
      end
    end
    applyStimulus(1'b0, 4'd0, 1'b1);
    tick();
    tests_run++;
    if (u0_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drain: got valid %b expected 0", u0_out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd7, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 1'b1);
    tests_run++;
    if (u0_out_valid !== 1'b1 || u0_out_vec !== 16'h0008 || u0_in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_full: got valid %b vec %h rdy %b expected 1 0008 0",
               u0_out_valid, u0_out_vec, u0_in_ready);
    end
    tick();
    tests_run++;
    if (u0_out_valid !== 1'b1 || u0_out_vec !== 16'h0008 || u0_in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_hold: got valid %b vec %h rdy %b expected 1 0008 0",
               u0_out_valid, u0_out_vec, u0_in_ready);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (u0_out_valid !== 1'b1 || u0_out_vec !== 16'h0080) begin
      tests_failed++;
      $display("[TB] FAIL bp_skid_out: got valid %b vec %h expected 1 0080",
               u0_out_valid, u0_out_vec);
    end
    tick();
    tests_run++;
    if (u0_out_valid !== 1'b0 || u0_in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_recover: got valid %b rdy %b expected 0 1",
               u0_out_valid, u0_in_ready);
    end
  endtask

  task automatic test_range();
    out_ready = 1'b1;
    applyStimulus(1'b1, 4'd12, 1'b1);
    tick();
    tests_run++;
    if (u1_out_vec !== 12'h000 || u1_out_err !== 1'b1 || u0_out_vec !== 16'h1000 || u0_out_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL range_12: got w12 %h err %b w16 %h err %b expected 000 1 1000 0",
               u1_out_vec, u1_out_err, u0_out_vec, u0_out_err);
    end
    applyStimulus(1'b1, 4'd11, 1'b1);
    tick();
    tests_run++;
    if (u1_out_vec !== 12'h800 || u1_out_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL range_11: got %h err %b expected 800 0", u1_out_vec, u1_out_err);
    end
    applyStimulus(1'b1, 4'd5, 1'b0);
    tick();
    tests_run++;
    if (u1_out_valid !== 1'b1 || u1_out_vec !== 12'h000 || u1_out_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL range_en0: got valid %b vec %h err %b expected 1 000 0",
               u1_out_valid, u1_out_vec, u1_out_err);
    end
    applyStimulus(1'b0, 4'd0, 1'b1);
    tick();
  endtask

  task automatic test_mode1();
    logic [3:0] idxs [3];
    logic [7:0] exps [3];
    idxs = '{4'd0, 4'd3, 4'd7};
    exps = '{8'h01, 8'h0F, 8'hFF};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, idxs[i], 1'b1);
      tick();
      tests_run++;
      if (u2_out_valid !== 1'b1 || u2_out_vec !== exps[i] || u2_out_err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL therm_%0d: got valid %b vec %h err %b expected 1 %h 0",
                 i, u2_out_valid, u2_out_vec, u2_out_err, exps[i]);
      end
    end
    applyStimulus(1'b0, 4'd0, 1'b1);
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd1, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd2, 1'b1);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 4'd9, 1'b1);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
    tests_run++;
    if (u0_out_valid !== 1'b0 || u0_in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_state: got valid %b rdy %b expected 0 1",
               u0_out_valid, u0_in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (u0_out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_leak_%0d: got valid %b vec %h expected valid 0",
                 i, u0_out_valid, u0_out_vec);
      end
    end
  endtask

`ifdef DECODER_PIPE_CNT_EN
  task automatic test_counter();
    logic [3:0] idxs [6];
    idxs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd13};
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, idxs[i], 1'b1);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b1);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (u1_cnt !== 32'd5 || u0_cnt !== 32'd6) begin
      tests_failed++;
      $display("[TB] FAIL cnt_after_flush: got w12 %0d w16 %0d expected 5 6", u1_cnt, u0_cnt);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tests_run++;
    if (u1_cnt !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL cnt_reset: got %0d expected 0", u1_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    bit          ov  [3];
    bit          ordy[3];
    bit          oerr[3];
    logic [63:0] ovec[3];
    bit          exp_valid;
    logic [63:0] exp_vec;
    bit          exp_err;
    int          eidx;
    resetn = 1'b0; flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      ov[0] = u0_out_valid; ordy[0] = u0_in_ready; oerr[0] = u0_out_err; ovec[0] = 64'(u0_out_vec);
      ov[1] = u1_out_valid; ordy[1] = u1_in_ready; oerr[1] = u1_out_err; ovec[1] = 64'(u1_out_vec);
      ov[2] = u2_out_valid; ordy[2] = u2_in_ready; oerr[2] = u2_out_err; ovec[2] = 64'(u2_out_vec);
      exp_valid = (mdl_q.size() != 0);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (ov[k] !== exp_valid || ordy[k] !== mdl_rdy) begin
          tests_failed++;
          $display("[TB] FAIL rand_hs cyc %0d dut %0d: got valid %b rdy %b expected %b %b",
                   c, k, ov[k], ordy[k], exp_valid, mdl_rdy);
        end
        if (exp_valid) begin
          eidx    = idx_for(k, mdl_q[0].idx);
          exp_vec = ref_vec(eidx, mdl_q[0].en, outw_for(k), mode_for(k));
          exp_err = ref_err(eidx, mdl_q[0].en, outw_for(k));
          tests_run++;
          if (ovec[k] !== exp_vec || oerr[k] !== exp_err) begin
            tests_failed++;
            $display("[TB] FAIL rand_data cyc %0d dut %0d: got %h err %b expected %h err %b",
                     c, k, ovec[k], oerr[k], exp_vec, exp_err);
          end
        end
      end
`ifdef DECODER_PIPE_CNT_EN
      tests_run++;
      if (u0_cnt !== mdl_cnt[0] || u1_cnt !== mdl_cnt[1] || u2_cnt !== mdl_cnt[2]) begin
        tests_failed++;
        $display("[TB] FAIL rand_cnt cyc %0d: got %0d %0d %0d expected %0d %0d %0d",
                 c, u0_cnt, u1_cnt, u2_cnt, mdl_cnt[0], mdl_cnt[1], mdl_cnt[2]);
      end
`endif
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 7) != 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      resetn    = 1'($urandom_range(0, 299) != 0);
      tick();
    end
    resetn = 1'b1; flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
  endtask

  // Run every scenario in order and report.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    resetn       = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b1);
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_range();
    test_mode1();
    test_flush();
`ifdef DECODER_PIPE_CNT_EN
    test_counter();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
